// File: rtl/pipeline_ctrl_pkg.sv
// +--------------------------------------------------------------------------+
// | Module      : pipeline_ctrl_pkg                                          |
// | Description : Shared types and constants for the pipeline flow control.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

package pipeline_ctrl_pkg;

    typedef enum logic {
        RUN       = 1'b0,
        DMEM_WAIT = 1'b1
    } flow_state_t;

    localparam int FLUSH_CTR_W = 3;

endpackage

`default_nettype wire

// File: rtl/pipeline_perf_cnt.sv
// +--------------------------------------------------------------------------+
// | Module      : pipeline_perf_cnt                                          |
// | Description : Enable-gated wrapping performance event counter.           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module pipeline_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + c_one;
        end
    end

    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/pipeline_flow_ctrl.sv
// +--------------------------------------------------------------------------+
// | Module      : pipeline_flow_ctrl                                         |
// | Description : Stall/flush scheduler producing per-stage enable/clear.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module pipeline_flow_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int TIMEOUT      = 255,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_use_stall,
    input  logic             ex_redirect,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             pc_sel_target,
    output logic             if_id_en,
    output logic             if_id_clr,
    output logic             id_ex_en,
    output logic             id_ex_clr,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             mem_wb_clr,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int c_wait_w = 16;
    localparam logic [FLUSH_CTR_W-1:0] c_flush_init = FLUSH_CTR_W'(FLUSH_CYCLES - 1);
    localparam logic [FLUSH_CTR_W-1:0] c_flush_one  = FLUSH_CTR_W'(1);
    localparam logic [c_wait_w-1:0]    c_timeout    = c_wait_w'(TIMEOUT);
    localparam logic [c_wait_w-1:0]    c_timeout_m1 = c_wait_w'(TIMEOUT - 1);
    localparam logic [c_wait_w-1:0]    c_wait_one   = c_wait_w'(1);

    generate
        if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7) begin : g_bad_flush_cycles
            $error("pipeline_flow_ctrl: FLUSH_CYCLES must be within 1..7");
        end
        if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
            $error("pipeline_flow_ctrl: TIMEOUT must be within 1..65535");
        end
    endgenerate

    flow_state_t             r_state;
    logic [FLUSH_CTR_W-1:0]  r_flush_ctr;
    logic [c_wait_w-1:0]     r_wait_ctr;
    logic                    r_mem_timeout;

    logic w_freeze;
    logic w_redirect;
    logic w_window;
    logic w_load_use;

    // Qualifying with rst_n keeps every stage enabled while reset is held,
    // regardless of what the hazard inputs are doing.
    assign w_freeze   = rst_n & dmem_req & ~dmem_ready;
    assign w_redirect = rst_n & ex_redirect & ~w_freeze;
    assign w_window   = rst_n & (r_flush_ctr != '0) & ~w_freeze & ~w_redirect;
    assign w_load_use = rst_n & load_use_stall & (r_state == RUN)
                      & ~w_freeze & ~w_redirect & ~w_window;

    always_comb begin
        pc_en         = 1'b1;
        pc_sel_target = 1'b0;
        if_id_en      = 1'b1;
        if_id_clr     = 1'b0;
        id_ex_en      = 1'b1;
        id_ex_clr     = 1'b0;
        ex_mem_en     = 1'b1;
        mem_wb_en     = 1'b1;
        mem_wb_clr    = 1'b0;
        if (w_freeze) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else if (w_redirect) begin
            pc_sel_target = 1'b1;
            if_id_clr     = 1'b1;
            id_ex_clr     = 1'b1;
        end else if (w_window) begin
            if_id_clr = 1'b1;
        end else if (w_load_use) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_clr = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= RUN;
            r_flush_ctr   <= '0;
            r_wait_ctr    <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            // Leaving DMEM_WAIT happens on ready or on a dropped request alike.
            r_state <= w_freeze ? DMEM_WAIT : RUN;

            if (w_redirect) begin
                r_flush_ctr <= c_flush_init;
            end else if (w_window) begin
                r_flush_ctr <= r_flush_ctr - c_flush_one;
            end

            if (w_freeze) begin
                if (r_wait_ctr != c_timeout) begin
                    r_wait_ctr <= r_wait_ctr + c_wait_one;
                end
                if (r_wait_ctr == c_timeout_m1) begin
                    r_mem_timeout <= 1'b1;
                end
            end else begin
                r_wait_ctr <= '0;
            end
        end
    end

    assign mem_timeout = r_mem_timeout;

    pipeline_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (~pc_en),
        .count (stall_cnt)
    );

    pipeline_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_redirect),
        .count (flush_cnt)
    );

endmodule

`default_nettype wire
